// File: rtl/gate_input_conditioner_if.sv
// gate_input_conditioner_if
//   Bundles the raw gate inputs and their conditioned outputs.
//   master : drives the raw inputs and observes the outputs (board / testbench side)
//   slave  : the conditioner itself
//   Signals: t_raw, v_raw, c_raw (raw, asynchronous, bouncy)
//            T, V, C (debounced levels), t_rise, c_fall (one-cycle edge pulses)
//            ticket_count[15:0] (only when GATE_TICKET_CNT_EN is defined)
interface gate_input_conditioner_if;
    logic        t_raw;
    logic        v_raw;
    logic        c_raw;
    logic        T;
    logic        V;
    logic        C;
    logic        t_rise;
    logic        c_fall;
`ifdef GATE_TICKET_CNT_EN
    logic [15:0] ticket_count;
`endif

    modport master (
        output t_raw, v_raw, c_raw,
        input  T, V, C, t_rise, c_fall
`ifdef GATE_TICKET_CNT_EN
        , input ticket_count
`endif
    );

    modport slave (
        input  t_raw, v_raw, c_raw,
        output T, V, C, t_rise, c_fall
`ifdef GATE_TICKET_CNT_EN
        , output ticket_count
`endif
    );
endinterface

// File: rtl/gate_input_conditioner.sv
// gate_input_conditioner
//   Front end of the parking-gate controller. Each of the three raw inputs
//   (ticket, validate, car) is synchronised, debounced, and presented as a
//   clean level; ticket insertion and car departure also get one-cycle pulses.
//   Ports:
//     clk  : system clock, rising edge
//     R_n  : asynchronous active-low reset
//     bus  : gate_input_conditioner_if.slave (t_raw/v_raw/c_raw in;
//            T/V/C, t_rise, c_fall, optional ticket_count out)
//   Parameters:
//     SYNC_STAGES : synchroniser depth per input (>=2)
//     DB_CYCLES   : consecutive stable synced cycles before a level changes (>=2)
//   Optional feature macro: GATE_TICKET_CNT_EN adds a saturating 16-bit count
//   of t_rise pulses on bus.ticket_count.
module gate_input_conditioner #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 1_000_000
) (
    input  logic                      clk,
    input  logic                      R_n,
    gate_input_conditioner_if.slave   bus
);

    localparam int unsigned NCH   = 3;   // 0 = ticket, 1 = validate, 2 = car
    localparam int unsigned CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic {
        DB_IDLE,
        DB_COUNT
    } db_state_e;

    logic [SYNC_STAGES-1:0] sync_q  [NCH];
    logic [SYNC_STAGES-1:0] sync_d  [NCH];
    db_state_e              state_q [NCH];
    db_state_e              state_d [NCH];
    logic [CNT_W-1:0]       cnt_q   [NCH];
    logic [CNT_W-1:0]       cnt_d   [NCH];
    logic [NCH-1:0]         stable_q;
    logic [NCH-1:0]         stable_d;
    logic [NCH-1:0]         raw;
    logic [NCH-1:0]         s;
    logic                   t_hist_q;
    logic                   t_hist_d;
    logic                   c_hist_q;
    logic                   c_hist_d;
    logic                   t_rise;
    logic                   c_fall;

    assign raw = {bus.c_raw, bus.v_raw, bus.t_raw};

    // Synchroniser chains: new sample enters bit 0, synced value leaves the MSB.
    always_comb begin
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
            s[ch]      = sync_q[ch][SYNC_STAGES-1];
        end
    end

    // Debouncer next-state logic, one FSM per channel.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            unique case (state_q[ch])
                DB_IDLE: begin
                    cnt_d[ch] = '0;
                    if (s[ch] != stable_q[ch]) begin
                        state_d[ch] = DB_COUNT;
                        cnt_d[ch]   = CNT_W'(1);
                    end
                end
                DB_COUNT: begin
                    if (s[ch] == stable_q[ch]) begin
                        // Glitch shorter than the window: drop it and restart.
                        state_d[ch] = DB_IDLE;
                        cnt_d[ch]   = '0;
                    end else if (cnt_q[ch] == CNT_LAST) begin
                        stable_d[ch] = s[ch];
                        state_d[ch]  = DB_IDLE;
                        cnt_d[ch]    = '0;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[ch] = DB_IDLE;
                    cnt_d[ch]   = '0;
                end
            endcase
        end
    end

    // Edge history; history resets to 0 so c_fall cannot fire at reset release.
    always_comb begin
        t_hist_d = stable_q[0];
        c_hist_d = stable_q[2];
        t_rise   = stable_q[0] & ~t_hist_q;
        c_fall   = ~stable_q[2] & c_hist_q;
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                sync_q[ch]  <= '0;
                state_q[ch] <= DB_IDLE;
                cnt_q[ch]   <= '0;
            end
            stable_q <= '0;
            t_hist_q <= 1'b0;
            c_hist_q <= 1'b0;
        end else begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                sync_q[ch]  <= sync_d[ch];
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            stable_q <= stable_d;
            t_hist_q <= t_hist_d;
            c_hist_q <= c_hist_d;
        end
    end

    assign bus.T      = stable_q[0];
    assign bus.V      = stable_q[1];
    assign bus.C      = stable_q[2];
    assign bus.t_rise = t_rise;
    assign bus.c_fall = c_fall;

`ifdef GATE_TICKET_CNT_EN
    logic [15:0] ticket_cnt_q;
    logic [15:0] ticket_cnt_d;

    // Saturating count, updated in the cycle after each t_rise.
    always_comb begin
        ticket_cnt_d = ticket_cnt_q;
        if (t_rise && (ticket_cnt_q != '1)) begin
            ticket_cnt_d = ticket_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            ticket_cnt_q <= '0;
        end else begin
            ticket_cnt_q <= ticket_cnt_d;
        end
    end

    assign bus.ticket_count = ticket_cnt_q;
`endif

endmodule

// File: tb/tb_gate_input_conditioner.sv
// tb_gate_input_conditioner
//   Directed stimulus for gate_input_conditioner with SYNC_STAGES=2, DB_CYCLES=4.
//   Every change of the output vector {T,V,C,t_rise,c_fall} is matched against
//   a queue of expected (edge number, vector) entries pushed by the stimulus.
module tb_gate_input_conditioner;

    logic        clk = 1'b0;
    logic        R_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned b;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  vec;
    } exp_t;

    exp_t        exp_q[$];
    logic [4:0]  prev_vec = '0;

    gate_input_conditioner_if bus();

    gate_input_conditioner #(
        .SYNC_STAGES (2),
        .DB_CYCLES   (4)
    ) dut (
        .clk (clk),
        .R_n (R_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] out_vec();
        return {bus.T, bus.V, bus.C, bus.t_rise, bus.c_fall};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int unsigned c, input logic [4:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_neg(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every observed output change must be the next expected entry.
    always @(negedge clk) begin
        logic [4:0] v;
        exp_t       e;
        v = out_vec();
        if (v !== prev_vec) begin
            if (exp_q.size() == 0) begin
                check("unexpected_change", {27'd0, v}, {27'd0, prev_vec});
            end else begin
                e = exp_q.pop_front();
                check("change_edge", e.cyc == cyc ? e.cyc : cyc, e.cyc);
                check("change_vec", {27'd0, v}, {27'd0, e.vec});
            end
            prev_vec = v;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        // 1: reset held with all raw inputs high, then release
        bus.t_raw = 1'b1;
        bus.v_raw = 1'b1;
        bus.c_raw = 1'b1;
        wait_neg(3);
        check("reset_outputs", {27'd0, out_vec()}, 32'd0);
        R_n = 1'b1;
        b = cyc;
        push(b + 6, 5'b11110);
        push(b + 7, 5'b11100);
        wait_neg(10);

        // bring T back to 0 for the ticket glitch tests
        bus.t_raw = 1'b0;
        b = cyc;
        push(b + 6, 5'b01100);
        wait_neg(10);

        // 2a: 3-cycle ticket pulse is rejected
        bus.t_raw = 1'b1;
        wait_neg(3);
        bus.t_raw = 1'b0;
        wait_neg(10);
        check("glitch3_T", {31'd0, bus.T}, 32'd0);

        // 2b: 4-cycle ticket pulse is accepted, then its release is too
        bus.t_raw = 1'b1;
        b = cyc;
        push(b + 6, 5'b11110);
        push(b + 7, 5'b11100);
        push(b + 10, 5'b01100);
        wait_neg(4);
        bus.t_raw = 1'b0;
        wait_neg(12);

        // 3: car leaves
        bus.t_raw = 1'b1;
        b = cyc;
        push(b + 6, 5'b11110);
        push(b + 7, 5'b11100);
        wait_neg(10);
        bus.c_raw = 1'b0;
        b = cyc;
        push(b + 6, 5'b11001);
        push(b + 7, 5'b11000);
        wait_neg(10);
        check("car_left_TV", {30'd0, bus.T, bus.V}, 32'd3);

        // 4: car sensor bounces every 2 cycles, then settles high
        for (int i = 0; i < 10; i++) begin
            bus.c_raw = ~bus.c_raw;
            wait_neg(2);
        end
        check("bounce_C", {31'd0, bus.C}, 32'd0);
        bus.c_raw = 1'b1;
        b = cyc;
        push(b + 6, 5'b11100);
        wait_neg(10);

        // 5: reset dropped between edges while the ticket debouncer is mid-count
        bus.t_raw = 1'b0;
        b = cyc;
        push(b + 6, 5'b01100);
        wait_neg(10);
        bus.t_raw = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        R_n = 1'b0;
        push(cyc, 5'b00000);
        #1;
        check("async_reset", {27'd0, out_vec()}, 32'd0);
        @(negedge clk);
        bus.t_raw = 1'b0;
        bus.v_raw = 1'b0;
        bus.c_raw = 1'b0;
        wait_neg(3);
        R_n = 1'b1;
        wait_neg(12);
        check("release_raw0", {27'd0, out_vec()}, 32'd0);

`ifdef GATE_TICKET_CNT_EN
        // 6: ticket counter, normal and saturating
        check("tcnt_zero", {16'd0, bus.ticket_count}, 32'd0);
        for (int p = 0; p < 3; p++) begin
            bus.t_raw = 1'b1;
            b = cyc;
            push(b + 6, 5'b10010);
            push(b + 7, 5'b10000);
            push(b + 14, 5'b00000);
            wait_neg(8);
            bus.t_raw = 1'b0;
            wait_neg(10);
        end
        check("tcnt_three", {16'd0, bus.ticket_count}, 32'd3);
        force dut.ticket_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.ticket_cnt_q;
        for (int p = 0; p < 2; p++) begin
            bus.t_raw = 1'b1;
            b = cyc;
            push(b + 6, 5'b10010);
            push(b + 7, 5'b10000);
            push(b + 14, 5'b00000);
            wait_neg(8);
            bus.t_raw = 1'b0;
            wait_neg(10);
        end
        check("tcnt_sat", {16'd0, bus.ticket_count}, 32'h0000FFFF);
`endif

        wait_neg(2);
        check("pending_expect", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
